// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Optional feature macro used by the fetch files: FETCH_FAULT_EN.
package rv_fetch_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// ROM, decode and control signals of the fetch sequencer.
// The master modport is the fetch controller; slave is its environment.
interface instr_fetch_ctrl_if;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        halted;
    logic        fetch_fault;

    modport master (
        output rom_addr, instr_valid, instr, instr_pc, halted, fetch_fault,
        input  rom_data, instr_ready, redirect_valid, redirect_pc, halt_req
    );

    modport slave (
        input  rom_addr, instr_valid, instr, instr_pc, halted, fetch_fault,
        output rom_data, instr_ready, redirect_valid, redirect_pc, halt_req
    );
endinterface

// File: rtl/instr_fetch_ctrl_fifo.sv
// Small synchronous FIFO of {pc,instr} fetch entries; flush beats push.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
    import rv_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_data,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          do_push, do_pop;
    fetch_entry_t  slots [DEPTH];

    assign empty   = (count_q == '0);
    assign full    = (count_q == DEPTH_C);
    assign do_pop  = pop && !empty;
    assign do_push = push && !flush && (!full || do_pop);
    assign head    = slots[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        fetch_entry_t slot_q, slot_d;

        always_comb begin
            slot_d = slot_q;
            if (do_push && (wr_ptr_q == PW'(gi))) slot_d = push_data;
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) slot_q <= '0;
            else          slot_q <= slot_d;
        end

        assign slots[gi] = slot_q;
    end
endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the PC, drives the ROM address and queues {pc,instr} for decode.
// FETCH_FAULT_EN enables misaligned/out-of-range fetch faults; otherwise targets are word-aligned.
module instr_fetch_ctrl
    import rv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          ROM_WORDS = 256,
    parameter int          BUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    instr_fetch_ctrl_if.master bus
);
    if (BUF_DEPTH < 2 || (BUF_DEPTH & (BUF_DEPTH - 1)) != 0 || ROM_WORDS < 1) begin : g_param_check
        $error("instr_fetch_ctrl: BUF_DEPTH must be a power of two >= 2 and ROM_WORDS >= 1");
    end

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  redirect_target;
    logic         push, pop, flush, fault_hit;
    logic         fifo_full, fifo_empty;
    fetch_entry_t push_entry, head_entry;

`ifdef FETCH_FAULT_EN
    localparam logic [32:0] ROM_LIMIT = 33'(ROM_WORDS) * 33'd4;

    assign redirect_target = bus.redirect_pc;
    assign fault_hit       = (pc_q[1:0] != 2'b00) || ({1'b0, pc_q} >= ROM_LIMIT);
    assign bus.fetch_fault = (state_q == FAULT);
`else
    logic unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];
    assign redirect_target      = {bus.redirect_pc[31:2], 2'b00};
    assign fault_hit            = 1'b0;
    assign bus.fetch_fault      = 1'b0;
`endif

    assign pop        = !fifo_empty && bus.instr_ready;
    assign push_entry = '{pc: pc_q, instr: bus.rom_data};

    // Redirect outranks every state transition except leaving BOOT.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        push    = 1'b0;
        flush   = 1'b0;
        if (bus.redirect_valid && state_q != BOOT) begin
            flush   = 1'b1;
            pc_d    = redirect_target;
            state_d = RUN;
        end else begin
            case (state_q)
                BOOT: state_d = RUN;
                RUN: begin
                    if (bus.halt_req) begin
                        state_d = HALT;
                    end else if (fault_hit) begin
                        state_d = FAULT;
                    end else if (!fifo_full || pop) begin
                        push = 1'b1;
                        pc_d = pc_q + 32'd4;
                    end
                end
                HALT:    if (!bus.halt_req) state_d = RUN;
                FAULT:   state_d = FAULT;
                default: state_d = BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .pop       (pop),
        .flush     (flush),
        .push_data (push_entry),
        .head      (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign bus.rom_addr    = pc_q;
    assign bus.instr_valid = !fifo_empty;
    assign bus.instr       = fifo_empty ? NOP_INSTR : head_entry.instr;
    assign bus.instr_pc    = fifo_empty ? 32'h0 : head_entry.pc;
    assign bus.halted      = (state_q == HALT) && fifo_empty;
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Randomized bench for instr_fetch_ctrl against a queue-based reference model,
// with directed scenarios pinned by hand-computed values.
module tb_instr_fetch_ctrl;
    import rv_fetch_pkg::*;

    localparam int DEPTH     = 2;
    localparam int ROM_WORDS = 256;
`ifdef FETCH_FAULT_EN
    localparam bit FAULT_EN = 1'b1;
`else
    localparam bit FAULT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    instr_fetch_ctrl_if bus_if();

    instr_fetch_ctrl #(
        .RESET_PC  (32'h0000_0000),
        .ROM_WORDS (ROM_WORDS),
        .BUF_DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    function automatic logic [31:0] rom_word(input logic [31:0] addr);
        return 32'h1000_0000 + {24'h0, addr[9:2]};
    endfunction

    assign bus_if.rom_data = rom_word(bus_if.rom_addr);

    int vectors = 0;
    int miscompares = 0;

    // Reference model: mode, pc and a queue of pending entries
    fetch_state_e m_mode;
    logic [31:0]  m_pc;
    logic [31:0]  q_pc[$];
    logic [31:0]  q_in[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit bad_pc(input logic [31:0] pc);
        return FAULT_EN && ((pc[1:0] != 2'b00) || (64'(pc) >= 64'(ROM_WORDS) * 4));
    endfunction

    task automatic model_reset();
        m_mode = BOOT;
        m_pc   = 32'h0;
        q_pc.delete();
        q_in.delete();
    endtask

    task automatic model_step(input bit rdy, input bit rv, input logic [31:0] rpc, input bit hr);
        int sz0;
        bit pop;
        logic [31:0] tgt;
        sz0 = q_pc.size();
        pop = (sz0 > 0) && rdy;
        tgt = FAULT_EN ? rpc : {rpc[31:2], 2'b00};
        if (m_mode != BOOT && rv) begin
            q_pc.delete();
            q_in.delete();
            m_pc   = tgt;
            m_mode = RUN;
        end else begin
            if (pop) begin
                void'(q_pc.pop_front());
                void'(q_in.pop_front());
            end
            case (m_mode)
                BOOT: m_mode = RUN;
                RUN: begin
                    if (hr) m_mode = HALT;
                    else if (bad_pc(m_pc)) m_mode = FAULT;
                    else if (sz0 < DEPTH || pop) begin
                        q_pc.push_back(m_pc);
                        q_in.push_back(rom_word(m_pc));
                        m_pc = m_pc + 32'd4;
                    end
                end
                HALT: if (!hr) m_mode = RUN;
                default: ;
            endcase
        end
    endtask

    task automatic check_model();
        bit v;
        v = q_pc.size() > 0;
        chk("instr_valid", 32'(bus_if.instr_valid), 32'(v));
        chk("instr",       bus_if.instr,    v ? q_in[0] : NOP_INSTR);
        chk("instr_pc",    bus_if.instr_pc, v ? q_pc[0] : 32'h0);
        chk("rom_addr",    bus_if.rom_addr, m_pc);
        chk("halted",      32'(bus_if.halted), 32'((m_mode == HALT) && !v));
        chk("fetch_fault", 32'(bus_if.fetch_fault), 32'(m_mode == FAULT));
    endtask

    // Called at a negedge: drive inputs, advance one clock, re-check at the next negedge.
    task automatic cycle(input bit rdy, input bit rv, input logic [31:0] rpc, input bit hr);
        bus_if.instr_ready    = rdy;
        bus_if.redirect_valid = rv;
        bus_if.redirect_pc    = rpc;
        bus_if.halt_req       = hr;
        @(posedge clk);
        if (reset_n) model_step(rdy, rv, rpc, hr);
        @(negedge clk);
        check_model();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_valid"},    32'(bus_if.instr_valid), 32'h0);
        chk({tag, "_instr"},    bus_if.instr, 32'h0000_0013);
        chk({tag, "_pc"},       bus_if.instr_pc, 32'h0);
        chk({tag, "_rom_addr"}, bus_if.rom_addr, 32'h0);
        chk({tag, "_halted"},   32'(bus_if.halted), 32'h0);
        chk({tag, "_fault"},    32'(bus_if.fetch_fault), 32'h0);
    endtask

    initial begin
        bit hr;
        logic [31:0] tgt;
        bus_if.instr_ready    = 1'b0;
        bus_if.redirect_valid = 1'b0;
        bus_if.redirect_pc    = 32'h0;
        bus_if.halt_req       = 1'b0;
        model_reset();

        // Reset state
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        check_model();
        reset_n = 1'b1;

        // Boot cycle, then stall with ready low: FIFO fills with pc 0,4 and pc freezes at 8
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        chk("boot_no_valid", 32'(bus_if.instr_valid), 32'h0);
        repeat (5) cycle(1'b0, 1'b0, 32'h0, 1'b0);
        chk("stall_rom_addr", bus_if.rom_addr, 32'h8);
        chk("stall_head_pc",  bus_if.instr_pc, 32'h0);
        chk("stall_head",     bus_if.instr,    32'h1000_0000);

        // Release: heads advance 4, 8, C
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        chk("resume_pc4", bus_if.instr_pc, 32'h4);
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        chk("resume_pc8", bus_if.instr_pc, 32'h8);
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        chk("resume_pcC", bus_if.instr_pc, 32'hC);

        // Redirect while full
        cycle(1'b0, 1'b1, 32'h40, 1'b0);
        chk("redir_flush_valid", 32'(bus_if.instr_valid), 32'h0);
        chk("redir_rom_addr",    bus_if.rom_addr, 32'h40);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        chk("redir_target_pc",   bus_if.instr_pc, 32'h40);
        chk("redir_target_ins",  bus_if.instr,    32'h1000_0010);

        // Halt with two entries buffered
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b1);
        chk("halt_pop1_pc", bus_if.instr_pc, 32'h44);
        cycle(1'b1, 1'b0, 32'h0, 1'b1);
        chk("halt_done",  32'(bus_if.halted), 32'h1);
        repeat (3) cycle(1'b1, 1'b0, 32'h0, 1'b1);
        chk("halt_frozen", bus_if.rom_addr, 32'h48);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        chk("unhalt_halted", 32'(bus_if.halted), 32'h0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        chk("unhalt_resume_pc", bus_if.instr_pc, 32'h48);

        // Misaligned redirect
        cycle(1'b1, 1'b1, 32'h42, 1'b0);
        chk("mis_rom_addr", bus_if.rom_addr, FAULT_EN ? 32'h42 : 32'h40);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        chk("mis_fault", 32'(bus_if.fetch_fault), FAULT_EN ? 32'h1 : 32'h0);
        chk("mis_valid", 32'(bus_if.instr_valid), FAULT_EN ? 32'h0 : 32'h1);
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b1, 32'h0, 1'b0);
        chk("clear_fault", 32'(bus_if.fetch_fault), 32'h0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        chk("clear_pc0", bus_if.instr_pc, 32'h0);

        // Randomized traffic
        hr = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 29) == 0) hr = ~hr;
            case ($urandom_range(0, 15))
                0:       tgt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 4;
                1, 2:    tgt = $urandom & 32'h0000_07FF;
                default: tgt = 32'($urandom_range(0, ROM_WORDS - 1)) * 4;
            endcase
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, tgt, hr);
        end

        // Keep a stream going, then hit reset between clock edges
        cycle(1'b1, 1'b1, 32'h80, 1'b0);
        repeat (4) cycle(1'b1, 1'b0, 32'h0, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        check_reset_values("midreset");
        model_reset();
        @(negedge clk);
        check_model();
        reset_n = 1'b1;
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        chk("post_reset_pc0", bus_if.instr_pc, 32'h0);
        repeat (6) cycle(1'b1, 1'b0, 32'h0, 1'b0);
        chk("post_reset_pc18", bus_if.instr_pc, 32'h18);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
